// File: rtl/avalon_pkg.sv
// avalon_pkg: shared Avalon bus device map, master FSM states and request record
package avalon_pkg;
   localparam int BUS_AW = 16;
   localparam int BUS_DW = 16;
   localparam logic [3:0] DEV_MEM = 4'h0;
   localparam logic [3:0] DEV_FP = 4'h1;
   typedef enum logic [1:0] {IDLE, REQ, RDLAT, RESP} bm_state_t;
   typedef struct packed {
      logic              write;
      logic [BUS_AW-1:0] addr;
      logic [BUS_DW-1:0] wdata;
   } bm_req_t;
endpackage

// File: rtl/avalon_bus_master.sv
// avalon_bus_master: single-outstanding load/store initiator for the Avalon bus; BUS_TIMEOUT_EN enables the Waitreq timeout abort
module avalon_bus_master
   import avalon_pkg::*;
#(
   parameter int ADDR_W         = BUS_AW,
   parameter int DATA_W         = BUS_DW,
   parameter int READ_LATENCY   = 1,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              Clock,
   input  logic              Resetn,
   input  logic              req_valid,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              req_ready,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic              Busy,
   output logic [ADDR_W-1:0] DataAddr,
   output logic [DATA_W-1:0] BusIn,
   output logic              ReadData,
   output logic              WriteData,
   input  logic [DATA_W-1:0] BusOut,
   input  logic              Waitreq
);
   bm_state_t         state_q, state_d;
   bm_req_t           req_q, req_d;
   logic [1:0]        lat_q, lat_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;
   logic              strobe;
`ifdef BUS_TIMEOUT_EN
   logic [7:0]        to_q, to_d;
   always_ff @(posedge Clock or negedge Resetn)
      if (!Resetn) to_q <= '0;
      else to_q <= to_d;
`endif
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q <= IDLE;
         req_q   <= '0;
         lat_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         lat_q   <= lat_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      lat_d   = lat_q;
      rdata_d = rdata_q;
      err_d   = err_q;
`ifdef BUS_TIMEOUT_EN
      to_d    = to_q;
`endif
      case (state_q)
         IDLE: if (req_valid) begin
            req_d   = '{write: req_write, addr: req_addr, wdata: req_wdata};
            rdata_d = '0;
            err_d   = 1'b0;
`ifdef BUS_TIMEOUT_EN
            to_d    = '0;
`endif
            state_d = REQ;
         end
         REQ: if (!Waitreq) begin
            if (req_q.write) state_d = RESP;
            else if (READ_LATENCY == 0) begin
               rdata_d = BusOut;
               state_d = RESP;
            end else begin
               lat_d   = 2'(READ_LATENCY);
               state_d = RDLAT;
            end
         end
`ifdef BUS_TIMEOUT_EN
         else if (to_q == 8'(TIMEOUT_CYCLES - 1)) begin
            err_d   = 1'b1;
            state_d = RESP;
         end else to_d = to_q + 8'd1;
`endif
         RDLAT: begin
            lat_d = lat_q - 2'd1;
            if (lat_q == 2'd1) begin
               rdata_d = BusOut;
               state_d = RESP;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   assign strobe     = state_q == REQ;
   assign req_ready  = state_q == IDLE;
   assign Busy       = state_q != IDLE;
   assign ReadData   = strobe & ~req_q.write;
   assign WriteData  = strobe & req_q.write;
   assign DataAddr   = strobe ? req_q.addr : '0;
   assign BusIn      = strobe ? req_q.wdata : '0;
   assign resp_valid = state_q == RESP;
   assign resp_rdata = rdata_q;
`ifdef BUS_TIMEOUT_EN
   assign resp_err   = err_q;
`else
   // err_q can never be set without the timeout; the limit is kept for a uniform parameter list
   logic unused_timeout;
   assign unused_timeout = err_q ^ (^TIMEOUT_CYCLES);
   assign resp_err   = 1'b0;
`endif
endmodule

// File: tb/tb_avalon_bus_master.sv
// tb_avalon_bus_master: directed table, reset/timeout sequences and random transfers against a transaction-level model
module tb_avalon_bus_master;
   localparam int LAT = 1;
   localparam int TO  = 8;
   logic        Clock = 1'b0;
   logic        Resetn, req_valid, req_write, Waitreq;
   logic [15:0] req_addr, req_wdata, BusOut;
   logic        req_ready, resp_valid, resp_err, Busy, ReadData, WriteData;
   logic [15:0] resp_rdata, DataAddr, BusIn;
   int vectors = 0, miscompares = 0;
   logic [15:0] ref_mem [logic [15:0]];
   logic [15:0] bus_mem [logic [15:0]];

   typedef struct {
      logic        w;
      logic [15:0] addr;
      logic [15:0] wdata;
      int          waits;
      logic [15:0] exp_rdata;
   } vec_t;
   vec_t tbl[$];

   always #5 Clock = ~Clock;

   avalon_bus_master #(.READ_LATENCY(LAT), .TIMEOUT_CYCLES(TO)) dut (
      .Clock(Clock), .Resetn(Resetn), .req_valid(req_valid), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .Busy(Busy),
      .DataAddr(DataAddr), .BusIn(BusIn), .ReadData(ReadData), .WriteData(WriteData),
      .BusOut(BusOut), .Waitreq(Waitreq)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // One transfer, issued at a negedge; Waitreq is held for 'waits' strobe cycles.
   task automatic txn(input logic w, input logic [15:0] addr, input logic [15:0] wdata,
                      input int waits, input logic [15:0] exp_rdata, input bit exp_to);
      int cyc, strobes, left, rd_cnt, exp_cyc, exp_str;
      bit pending, done, bad, busy_bad;
      logic [15:0] rdata;
      logic err;
      cyc = 0; strobes = 0; left = waits; rd_cnt = 0;
      pending = 0; done = 0; bad = 0; busy_bad = 0; rdata = 'x; err = 'x;
      exp_cyc = exp_to ? TO + 1 : 2 + waits + (w ? 0 : LAT);
      exp_str = exp_to ? TO : 1 + waits;
      chk("issue_ready", req_ready, 1);
      req_valid = 1; req_write = w; req_addr = addr; req_wdata = wdata;
      Waitreq = 1'($urandom_range(0, 1));
      while (!done && cyc < 400) begin
         @(negedge Clock);
         cyc++;
         req_valid = 1'($urandom_range(0, 1));
         req_write = 1'($urandom_range(0, 1));
         req_addr = 16'h0020;
         req_wdata = 16'($urandom);
         busy_bad |= !Busy | req_ready;
         if (ReadData | WriteData) begin
            strobes++;
            bad |= (DataAddr !== addr) | (WriteData !== w) | (ReadData !== !w) | (w && BusIn !== wdata);
            if (left > 0) begin
               Waitreq = 1;
               left--;
            end else begin
               Waitreq = 0;
               if (w) bus_mem[addr] = wdata;
               else begin
                  pending = 1;
                  rd_cnt = LAT;
               end
            end
         end else begin
            bad |= (DataAddr !== 16'h0) | (BusIn !== 16'h0);
            Waitreq = 1'($urandom_range(0, 1));
         end
         if (pending && rd_cnt == 0) begin
            BusOut = bus_mem.exists(addr) ? bus_mem[addr] : 16'h0;
            pending = 0;
         end else begin
            BusOut = 16'($urandom);
            if (pending) rd_cnt--;
         end
         if (resp_valid) begin
            done = 1;
            rdata = resp_rdata;
            err = resp_err;
            req_valid = 0;
         end
      end
      req_valid = 0;
      chk("resp_seen", done, 1);
      chk("latency", cyc, exp_cyc);
      chk("strobe_cycles", strobes, exp_str);
      chk("strobe_stable", bad, 0);
      chk("busy_during", busy_bad, 0);
      chk("rdata", rdata, exp_rdata);
      chk("err", err, exp_to);
      if (w && !exp_to) ref_mem[addr] = wdata;
      @(negedge Clock);
      Waitreq = 1'($urandom_range(0, 1));
      chk("resp_pulse", resp_valid, 0);
      chk("idle_ready", req_ready, 1);
      chk("idle_busy", Busy, 0);
      chk("no_strobe", ReadData | WriteData, 0);
   endtask

   initial begin
      logic        w;
      logic [15:0] a, d, e;
      Resetn = 0; req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0;
      BusOut = 0; Waitreq = 0;
      repeat (2) @(negedge Clock);
      chk("rst_busy", Busy, 0);
      chk("rst_ready", req_ready, 1);
      chk("rst_strobes", {ReadData, WriteData}, 0);
      chk("rst_addr", DataAddr, 0);
      chk("rst_busin", BusIn, 0);
      chk("rst_resp", {resp_valid, resp_err}, 0);
      chk("rst_rdata", resp_rdata, 0);
      Resetn = 1;
      @(negedge Clock);

      tbl.push_back('{1, 16'h0010, 16'h1234, 0, 16'h0000});
      tbl.push_back('{0, 16'h0010, 16'h0000, 0, 16'h1234});
      tbl.push_back('{1, 16'h1002, 16'hBEEF, 5, 16'h0000});
      tbl.push_back('{0, 16'h1002, 16'h0000, 2, 16'hBEEF});
      tbl.push_back('{1, 16'h0FFF, 16'hFFFF, 1, 16'h0000});
      tbl.push_back('{0, 16'h0FFF, 16'h0000, 0, 16'hFFFF});
      tbl.push_back('{1, 16'h0042, 16'h5A5A, TO - 1, 16'h0000});
      tbl.push_back('{0, 16'h0042, 16'h0000, TO - 1, 16'h5A5A});
      tbl.push_back('{0, 16'h0010, 16'h0000, 3, 16'h1234});
      tbl.push_back('{0, 16'h1FFE, 16'h0000, 0, 16'h0000});
      foreach (tbl[i]) txn(tbl[i].w, tbl[i].addr, tbl[i].wdata, tbl[i].waits, tbl[i].exp_rdata, 0);

`ifdef BUS_TIMEOUT_EN
      txn(1, 16'h1004, 16'hCAFE, 20, 16'h0000, 1);
      txn(0, 16'h1004, 16'h0000, 0, 16'h0000, 0);
`endif

      req_valid = 1; req_write = 0; req_addr = 16'h0010; Waitreq = 0;
      @(negedge Clock);
      req_valid = 0; Waitreq = 1;
      repeat (2) @(negedge Clock);
      chk("stall_read", ReadData, 1);
      #2 Resetn = 0;
      #1;
      chk("rst_async_strobe", ReadData, 0);
      chk("rst_async_addr", DataAddr, 0);
      chk("rst_async_busy", Busy, 0);
      @(negedge Clock);
      chk("rst_no_resp", resp_valid, 0);
      Resetn = 1; Waitreq = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge Clock);
         chk("post_rst_quiet", {resp_valid, ReadData, WriteData, Busy}, 0);
      end

      repeat (60) begin
         w = 1'($urandom_range(0, 1));
         a = {3'b000, 1'($urandom_range(0, 1)), 8'h00, 4'($urandom_range(0, 15))};
         d = 16'($urandom);
         e = w ? 16'h0 : (ref_mem.exists(a) ? ref_mem[a] : 16'h0);
         txn(w, a, d, $urandom_range(0, 4), e, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
